// File: rtl/fpu_cvt_arbiter.sv
// Shares one int-to-single conversion datapath between two round-robin arbitrated requesters.
// Latency: 2 cycles from accepted request to rsp_valid_o (issue register A, result register B).
// Backpressure: rsp_ready_i low holds B stable, A fills, then reqN_ready_o drops; flush_i blocks accepts.
module fpu_cvt_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic [2:0]       frm_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic             req0_unsigned_i,
  input  logic [2:0]       req0_rm_i,
  input  logic [31:0]      req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic             req1_unsigned_i,
  input  logic [2:0]       req1_rm_i,
  input  logic [31:0]      req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_nx_o,
  output logic             rsp_illegal_o,
  output logic [CNT_W-1:0] conv_count_o
);

  // round-robin pointer: port favoured when both request
  logic             rr_ptr;

  // stage A: issue register
  logic             a_vld;
  logic             a_id;
  logic             a_unsigned;
  logic             a_illegal;
  logic [2:0]       a_rm;
  logic [31:0]      a_op;
  logic [TAG_W-1:0] a_tag;

  // stage B: result register
  logic             b_vld;
  logic             b_id;
  logic             b_nx;
  logic             b_illegal;
  logic [31:0]      b_result;
  logic [TAG_W-1:0] b_tag;

  logic [CNT_W-1:0] conv_cnt;

  // arbitration and pipeline handshake signals
  logic             grant0;
  logic             grant1;
  logic             b_adv;
  logic             a_to_b;
  logic             a_accept;
  logic             fire0;
  logic             fire1;
  logic             fire;
  logic [2:0]       sel_rm_raw;
  logic [2:0]       sel_rm;
  logic             sel_illegal;

  // conversion datapath signals
  logic             cv_sign;
  logic [31:0]      cv_mag;
  logic [4:0]       cv_msb;
  logic [31:0]      cv_norm;
  logic             cv_lsb;
  logic             cv_guard;
  logic             cv_sticky;
  logic             cv_inexact;
  logic             cv_inc;
  logic [30:0]      cv_expmant;
  logic [31:0]      cv_result;
  logic             cv_nx;

  // grant selection and flow control; ready depends only on valids, pointer and pipeline state
  always_comb begin
    grant0       = req0_valid_i & (~req1_valid_i | ~rr_ptr);
    grant1       = req1_valid_i & (~req0_valid_i |  rr_ptr);
    b_adv        = ~b_vld | rsp_ready_i;
    a_to_b       = a_vld & b_adv;
    a_accept     = ~a_vld | a_to_b;
    req0_ready_o = a_accept & grant0 & ~flush_i;
    req1_ready_o = a_accept & grant1 & ~flush_i;
    fire0        = req0_ready_o & req0_valid_i;
    fire1        = req1_ready_o & req1_valid_i;
    fire         = fire0 | fire1;
    sel_rm_raw   = grant1 ? req1_rm_i : req0_rm_i;
    // dynamic rounding mode is resolved against frm at grant time
    sel_rm       = (sel_rm_raw == 3'b111) ? frm_i : sel_rm_raw;
    sel_illegal  = (sel_rm == 3'b101) | (sel_rm == 3'b110) | (sel_rm == 3'b111);
  end

  // int32/uint32 to single conversion driven from stage A; exponent never overflows to inf
  always_comb begin
    cv_sign = ~a_unsigned & a_op[31];
    // two's complement negate maps 0x80000000 onto itself, which reads as 2^31 unsigned
    cv_mag  = cv_sign ? (~a_op + 32'd1) : a_op;
    cv_msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (cv_mag[i]) cv_msb = 5'(i);
    end
    // leading one lands in bit 31; bits 30:8 are the mantissa, bit 7 guard, 6:0 sticky
    cv_norm    = cv_mag << (5'd31 - cv_msb);
    cv_lsb     = cv_norm[8];
    cv_guard   = cv_norm[7];
    cv_sticky  = |cv_norm[6:0];
    cv_inexact = cv_guard | cv_sticky;
    case (a_rm)
      3'b000:  cv_inc = cv_guard & (cv_sticky | cv_lsb);
      3'b001:  cv_inc = 1'b0;
      3'b010:  cv_inc = cv_sign & cv_inexact;
      3'b011:  cv_inc = ~cv_sign & cv_inexact;
      3'b100:  cv_inc = cv_guard;
      default: cv_inc = 1'b0;
    endcase
    // mantissa carry-out ripples into the exponent field naturally
    cv_expmant = {8'd127 + {3'b000, cv_msb}, cv_norm[30:8]} + {30'd0, cv_inc};
    if (a_illegal || (cv_mag == 32'd0)) begin
      cv_result = 32'h0;
      cv_nx     = 1'b0;
    end else begin
      cv_result = {cv_sign, cv_expmant};
      cv_nx     = cv_inexact;
    end
  end

  // round-robin pointer moves away from the winner only when both ports contended
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr <= 1'b0;
    end else if (fire && req0_valid_i && req1_valid_i) begin
      rr_ptr <= fire0;
    end
  end

  // stage A: capture the granted request with its resolved rounding mode
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_vld      <= 1'b0;
      a_id       <= 1'b0;
      a_unsigned <= 1'b0;
      a_illegal  <= 1'b0;
      a_rm       <= 3'b000;
      a_op       <= 32'h0;
      a_tag      <= '0;
    end else if (flush_i) begin
      a_vld <= 1'b0;
    end else if (a_accept) begin
      a_vld <= fire;
      if (fire) begin
        a_id       <= fire1;
        a_unsigned <= fire1 ? req1_unsigned_i : req0_unsigned_i;
        a_illegal  <= sel_illegal;
        a_rm       <= sel_rm;
        a_op       <= fire1 ? req1_op_i : req0_op_i;
        a_tag      <= fire1 ? req1_tag_i : req0_tag_i;
      end
    end
  end

  // stage B: register the datapath result; held while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      b_vld     <= 1'b0;
      b_id      <= 1'b0;
      b_nx      <= 1'b0;
      b_illegal <= 1'b0;
      b_result  <= 32'h0;
      b_tag     <= '0;
    end else if (flush_i) begin
      b_vld <= 1'b0;
    end else if (b_adv) begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_id      <= a_id;
        b_nx      <= cv_nx;
        b_illegal <= a_illegal;
        b_result  <= cv_result;
        b_tag     <= a_tag;
      end
    end
  end

  // count handed-off results; a flush cancels a coincident handshake
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conv_cnt <= '0;
    end else if (b_vld && rsp_ready_i && !flush_i) begin
      conv_cnt <= conv_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid_o   = b_vld;
  assign rsp_id_o      = b_id;
  assign rsp_tag_o     = b_tag;
  assign rsp_result_o  = b_result;
  assign rsp_nx_o      = b_nx;
  assign rsp_illegal_o = b_illegal;
  assign conv_count_o  = conv_cnt;

endmodule
